// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: ALU control encodings, register-index width and issue-stage state type.
package alu_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_MUL   = 4'b0011;
  localparam logic [3:0] ALU_AUIPC = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;
  localparam logic [3:0] ALU_BEQ   = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SLTI  = 4'b1000;
  localparam logic [3:0] ALU_NOP   = 4'b1111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

endpackage
`default_nettype wire

// File: rtl/operand_forward.sv
`default_nettype none
// operand_forward: resolves one source operand through the EX/WB bypass network
// and flags a use of a not-yet-available load result.
module operand_forward
  import alu_pkg::*;
#(
  parameter int WIDTH = 31
) (
  input  logic [REG_IDX_W-1:0] i_idx,
  input  logic                 i_used,
  input  logic [WIDTH:0]       i_rf_data,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_is_load,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic [WIDTH:0]       i_ex_data,
  input  logic                 i_wb_valid,
  input  logic [REG_IDX_W-1:0] i_wb_rd,
  input  logic [WIDTH:0]       i_wb_data,
  output logic [WIDTH:0]       o_data,
  output logic                 o_load_hit
);

  always_comb begin
    o_data = i_rf_data;
    if (i_idx == '0) begin
      o_data = '0;
    end else if (i_ex_valid && !i_ex_is_load && (i_ex_rd == i_idx)) begin
      o_data = i_ex_data;
    end else if (i_wb_valid && (i_wb_rd == i_idx)) begin
      o_data = i_wb_data;
    end
  end

  // A load in EX has no data yet; the consumer must wait one cycle.
  assign o_load_hit = i_used && i_ex_valid && i_ex_is_load &&
                      (i_ex_rd != '0) && (i_ex_rd == i_idx);

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// alu_issue_stage: single-entry operand-select/forwarding register feeding the ALU,
// with load-use stall, flush and full-throughput valid/ready handshake.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 31
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic [WIDTH:0]              IN_PC,
  input  logic [WIDTH:0]              IN_RS1_DATA,
  input  logic [WIDTH:0]              IN_RS2_DATA,
  input  logic [REG_IDX_W-1:0]        IN_RS1,
  input  logic [REG_IDX_W-1:0]        IN_RS2,
  input  logic [REG_IDX_W-1:0]        IN_RD,
  input  logic [WIDTH:0]              IN_IMM,
  input  logic                        IN_USE_PC,
  input  logic                        IN_USE_IMM,
  input  logic [3:0]                  IN_CONTROL,
  input  logic                        IN_IS_LOAD,
  input  logic                        FLUSH,
  input  logic                        FWD_EX_VALID,
  input  logic                        FWD_EX_IS_LOAD,
  input  logic [REG_IDX_W-1:0]        FWD_EX_RD,
  input  logic [WIDTH:0]              FWD_EX_DATA,
  input  logic                        FWD_WB_VALID,
  input  logic [REG_IDX_W-1:0]        FWD_WB_RD,
  input  logic [WIDTH:0]              FWD_WB_DATA,
  input  logic                        OUT_READY,
  output logic                        OUT_VALID,
  output logic signed [WIDTH:0]       A,
  output logic signed [WIDTH:0]       B,
  output logic [3:0]                  REG_CONTROL,
  output logic [REG_IDX_W-1:0]        OUT_RD,
  output logic                        OUT_IS_LOAD
);

  stage_state_t          r_state;
  stage_state_t          w_state_next;
  logic [WIDTH:0]        w_rs1_fwd;
  logic [WIDTH:0]        w_rs2_fwd;
  logic                  w_rs1_load_hit;
  logic                  w_rs2_load_hit;
  logic                  w_hazard;
  logic                  w_capture;
  logic signed [WIDTH:0] r_a;
  logic signed [WIDTH:0] r_b;
  logic [3:0]            r_control;
  logic [REG_IDX_W-1:0]  r_rd;
  logic                  r_is_load;

  operand_forward #(.WIDTH(WIDTH)) u_fwd_rs1 (
    .i_idx        (IN_RS1),
    .i_used       (!IN_USE_PC),
    .i_rf_data    (IN_RS1_DATA),
    .i_ex_valid   (FWD_EX_VALID),
    .i_ex_is_load (FWD_EX_IS_LOAD),
    .i_ex_rd      (FWD_EX_RD),
    .i_ex_data    (FWD_EX_DATA),
    .i_wb_valid   (FWD_WB_VALID),
    .i_wb_rd      (FWD_WB_RD),
    .i_wb_data    (FWD_WB_DATA),
    .o_data       (w_rs1_fwd),
    .o_load_hit   (w_rs1_load_hit)
  );

  operand_forward #(.WIDTH(WIDTH)) u_fwd_rs2 (
    .i_idx        (IN_RS2),
    .i_used       (!IN_USE_IMM),
    .i_rf_data    (IN_RS2_DATA),
    .i_ex_valid   (FWD_EX_VALID),
    .i_ex_is_load (FWD_EX_IS_LOAD),
    .i_ex_rd      (FWD_EX_RD),
    .i_ex_data    (FWD_EX_DATA),
    .i_wb_valid   (FWD_WB_VALID),
    .i_wb_rd      (FWD_WB_RD),
    .i_wb_data    (FWD_WB_DATA),
    .o_data       (w_rs2_fwd),
    .o_load_hit   (w_rs2_load_hit)
  );

  assign w_hazard  = IN_VALID && (w_rs1_load_hit || w_rs2_load_hit);
  assign OUT_VALID = (r_state == ST_FULL);
  assign IN_READY  = (!OUT_VALID || OUT_READY) && !w_hazard && !FLUSH;
  assign w_capture = IN_VALID && IN_READY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flush dominates; a capture keeps the stage FULL even while draining.
  always_comb begin
    w_state_next = r_state;
    if (FLUSH) begin
      w_state_next = ST_EMPTY;
    end else if (w_capture) begin
      w_state_next = ST_FULL;
    end else if ((r_state == ST_FULL) && OUT_READY) begin
      w_state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_control <= ALU_NOP;
      r_rd      <= '0;
      r_is_load <= 1'b0;
    end else if (w_capture) begin
      r_a       <= IN_USE_PC  ? IN_PC  : w_rs1_fwd;
      r_b       <= IN_USE_IMM ? IN_IMM : w_rs2_fwd;
      r_control <= IN_CONTROL;
      r_rd      <= IN_RD;
      r_is_load <= IN_IS_LOAD;
    end
  end

  assign A           = r_a;
  assign B           = r_b;
  assign REG_CONTROL = r_control;
  assign OUT_RD      = r_rd;
  assign OUT_IS_LOAD = r_is_load;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// tb_alu_issue_stage: directed and random stimulus, reference model feeding a
// scoreboard queue, independent monitor comparing every held instruction.
module tb_alu_issue_stage;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   ctl;
    logic [4:0]   rd;
    logic         ld;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         IN_VALID, IN_READY;
  logic [W-1:0] IN_PC, IN_RS1_DATA, IN_RS2_DATA, IN_IMM;
  logic [4:0]   IN_RS1, IN_RS2, IN_RD;
  logic         IN_USE_PC, IN_USE_IMM, IN_IS_LOAD, FLUSH;
  logic [3:0]   IN_CONTROL;
  logic         FWD_EX_VALID, FWD_EX_IS_LOAD, FWD_WB_VALID;
  logic [4:0]   FWD_EX_RD, FWD_WB_RD;
  logic [W-1:0] FWD_EX_DATA, FWD_WB_DATA;
  logic         OUT_READY, OUT_VALID, OUT_IS_LOAD;
  logic [W-1:0] A, B;
  logic [3:0]   REG_CONTROL;
  logic [4:0]   OUT_RD;

  exp_t q[$];
  bit   m_full;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(W-1)) dut (
    .clk(clk), .reset(reset),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_PC(IN_PC),
    .IN_RS1_DATA(IN_RS1_DATA), .IN_RS2_DATA(IN_RS2_DATA),
    .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_RD(IN_RD), .IN_IMM(IN_IMM),
    .IN_USE_PC(IN_USE_PC), .IN_USE_IMM(IN_USE_IMM), .IN_CONTROL(IN_CONTROL),
    .IN_IS_LOAD(IN_IS_LOAD), .FLUSH(FLUSH),
    .FWD_EX_VALID(FWD_EX_VALID), .FWD_EX_IS_LOAD(FWD_EX_IS_LOAD),
    .FWD_EX_RD(FWD_EX_RD), .FWD_EX_DATA(FWD_EX_DATA),
    .FWD_WB_VALID(FWD_WB_VALID), .FWD_WB_RD(FWD_WB_RD), .FWD_WB_DATA(FWD_WB_DATA),
    .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID), .A(A), .B(B),
    .REG_CONTROL(REG_CONTROL), .OUT_RD(OUT_RD), .OUT_IS_LOAD(OUT_IS_LOAD)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Source value as seen by the instruction: x0 is zero, EX bypass beats WB, else RF.
  function automatic logic [W-1:0] src_value(input logic [4:0] idx, input logic [W-1:0] rf);
    if (idx == 0) return '0;
    if (FWD_EX_VALID && !FWD_EX_IS_LOAD && FWD_EX_RD == idx) return FWD_EX_DATA;
    if (FWD_WB_VALID && FWD_WB_RD == idx) return FWD_WB_DATA;
    return rf;
  endfunction

  function automatic bit load_use();
    bit needs1 = !IN_USE_PC  && (IN_RS1 == FWD_EX_RD);
    bit needs2 = !IN_USE_IMM && (IN_RS2 == FWD_EX_RD);
    return IN_VALID && FWD_EX_VALID && FWD_EX_IS_LOAD && FWD_EX_RD != 0 && (needs1 || needs2);
  endfunction

  task automatic set_idle();
    IN_VALID = 0; IN_PC = 0; IN_RS1_DATA = 0; IN_RS2_DATA = 0; IN_IMM = 0;
    IN_RS1 = 0; IN_RS2 = 0; IN_RD = 0; IN_USE_PC = 0; IN_USE_IMM = 0;
    IN_CONTROL = 4'hF; IN_IS_LOAD = 0; FLUSH = 0;
    FWD_EX_VALID = 0; FWD_EX_IS_LOAD = 0; FWD_EX_RD = 0; FWD_EX_DATA = 0;
    FWD_WB_VALID = 0; FWD_WB_RD = 0; FWD_WB_DATA = 0; OUT_READY = 1;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [W-1:0] d1, input logic [W-1:0] d2, input logic [3:0] ctl);
    IN_VALID = 1; IN_RS1 = rs1; IN_RS2 = rs2; IN_RD = rd;
    IN_RS1_DATA = d1; IN_RS2_DATA = d2; IN_CONTROL = ctl;
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic drive_cycle();
    bit   exp_rdy;
    exp_t e;
    #1;
    check("out_valid", OUT_VALID, m_full);
    exp_rdy = (!m_full || OUT_READY) && !load_use() && !FLUSH;
    check("in_ready", IN_READY, exp_rdy);
    if (IN_VALID && exp_rdy) begin
      e.a   = IN_USE_PC  ? IN_PC  : src_value(IN_RS1, IN_RS1_DATA);
      e.b   = IN_USE_IMM ? IN_IMM : src_value(IN_RS2, IN_RS2_DATA);
      e.ctl = IN_CONTROL; e.rd = IN_RD; e.ld = IN_IS_LOAD;
      q.push_back(e);
    end
    if (FLUSH) m_full = 0;
    else if (IN_VALID && exp_rdy) m_full = 1;
    else if (OUT_READY) m_full = 0;
    @(posedge clk); #1;
  endtask

  // Monitor: every cycle the stage holds something, it must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && OUT_VALID) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = q[0];
          check("A", A, e.a);
          check("B", B, e.b);
          check("REG_CONTROL", REG_CONTROL, e.ctl);
          check("OUT_RD", OUT_RD, e.rd);
          check("OUT_IS_LOAD", OUT_IS_LOAD, e.ld);
          if (OUT_READY || FLUSH) e = q.pop_front();
        end
      end
    end
  end

  initial begin
    reset = 1; set_idle(); m_full = 0;
    #3;
    check("rst_valid", OUT_VALID, 0);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_ctl", REG_CONTROL, 4'hF);
    check("rst_rd", OUT_RD, 0);
    check("rst_ld", OUT_IS_LOAD, 0);
    @(posedge clk); #1;
    reset = 0;
    drive_cycle();

    // ADD with plain register operands
    set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 4'b0010);
    drive_cycle();
    check("add_valid", OUT_VALID, 1);
    check("add_A", A, 5);
    check("add_B", B, 7);
    check("add_ctl", REG_CONTROL, 4'b0010);

    // Forwarding priority: EX over WB, then WB, then x0
    set_instr(5'd3, 5'd2, 5'd4, 32'd100, 32'd1, 4'b0000);
    FWD_EX_VALID = 1; FWD_EX_RD = 3; FWD_EX_DATA = 9;
    FWD_WB_VALID = 1; FWD_WB_RD = 3; FWD_WB_DATA = 4;
    drive_cycle();
    check("fwd_ex_A", A, 9);
    FWD_EX_VALID = 0;
    drive_cycle();
    check("fwd_wb_A", A, 4);
    IN_RS1 = 0; FWD_EX_VALID = 1; FWD_EX_RD = 0; FWD_WB_RD = 0;
    drive_cycle();
    check("fwd_x0_A", A, 0);
    set_idle();

    // Load-use stall on rs2, then release; same with immediate needs no stall
    set_instr(5'd1, 5'd6, 5'd7, 32'd11, 32'd22, 4'b0101);
    FWD_EX_VALID = 1; FWD_EX_IS_LOAD = 1; FWD_EX_RD = 6;
    drive_cycle();
    FWD_EX_VALID = 0; FWD_WB_VALID = 1; FWD_WB_RD = 6; FWD_WB_DATA = 32'h55;
    drive_cycle();
    set_instr(5'd1, 5'd6, 5'd8, 32'd11, 32'd22, 4'b1000);
    IN_USE_IMM = 1; IN_IMM = 32'hFFFF_FFF0;
    FWD_EX_VALID = 1; FWD_EX_IS_LOAD = 1; FWD_EX_RD = 6; FWD_WB_VALID = 0;
    drive_cycle();
    set_idle();

    // Backpressure for three cycles, then back-to-back captures
    set_instr(5'd9, 5'd10, 5'd11, 32'hA, 32'hB, 4'b0011);
    drive_cycle();
    OUT_READY = 0; IN_RS1_DATA = 32'hC;
    repeat (3) drive_cycle();
    OUT_READY = 1;
    drive_cycle();
    IN_RS1_DATA = 32'hD; IN_USE_PC = 1; IN_PC = 32'h1000;
    drive_cycle();

    // Flush with a valid offer and a consuming ALU stage
    set_instr(5'd1, 5'd2, 5'd3, 32'h77, 32'h88, 4'b0001);
    FLUSH = 1;
    drive_cycle();
    set_idle();
    drive_cycle();

    // Asynchronous reset while FULL
    set_instr(5'd4, 5'd5, 5'd6, 32'h123, 32'h456, 4'b0111);
    drive_cycle();
    set_idle(); OUT_READY = 0;
    #1;
    check("pre_rst_valid", OUT_VALID, 1);
    reset = 1;
    #1;
    check("mid_rst_valid", OUT_VALID, 0);
    check("mid_rst_ctl", REG_CONTROL, 4'hF);
    check("mid_rst_A", A, 0);
    q.delete(); m_full = 0;
    @(posedge clk); #1;
    reset = 0; OUT_READY = 1;
    drive_cycle();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      IN_VALID       = ($urandom_range(0, 3) != 0);
      IN_RS1         = 5'($urandom_range(0, 7));
      IN_RS2         = 5'($urandom_range(0, 7));
      IN_RD          = 5'($urandom_range(0, 31));
      IN_RS1_DATA    = $urandom;
      IN_RS2_DATA    = $urandom;
      IN_PC          = $urandom;
      IN_IMM         = $urandom;
      IN_USE_PC      = ($urandom_range(0, 3) == 0);
      IN_USE_IMM     = ($urandom_range(0, 2) == 0);
      IN_CONTROL     = 4'($urandom_range(0, 15));
      IN_IS_LOAD     = ($urandom_range(0, 3) == 0);
      FLUSH          = ($urandom_range(0, 15) == 0);
      FWD_EX_VALID   = ($urandom_range(0, 1) == 0);
      FWD_EX_IS_LOAD = ($urandom_range(0, 2) == 0);
      FWD_EX_RD      = 5'($urandom_range(0, 7));
      FWD_EX_DATA    = $urandom;
      FWD_WB_VALID   = ($urandom_range(0, 1) == 0);
      FWD_WB_RD      = 5'($urandom_range(0, 7));
      FWD_WB_DATA    = $urandom;
      OUT_READY      = ($urandom_range(0, 3) != 0);
      drive_cycle();
    end

    set_idle();
    repeat (3) drive_cycle();
    check("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 31; operands are WIDTH+1 bits, matching the ALU operand width.
REQ-002 SHALL have clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have reset  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have IN_VALID  in  1  the decode stage offers an instruction.
REQ-005 SHALL have IN_READY  out  1  this stage accepts the offered instruction this cycle.
REQ-006 SHALL have IN_PC  in  WIDTH+1  the instruction PC.
REQ-007 SHALL have IN_RS1_DATA and IN_RS2_DATA  in  WIDTH+1 each  the register-file read values.
REQ-008 SHALL have IN_RS1, IN_RS2, IN_RD  in  5 each  the source and destination register indices.
REQ-009 SHALL have IN_IMM  in  WIDTH+1  the sign-extended immediate.
REQ-010 SHALL have IN_USE_PC  in  1  A takes IN_PC instead of rs1.
REQ-011 SHALL have IN_USE_IMM  in  1  B takes IN_IMM instead of rs2.
REQ-012 SHALL have IN_CONTROL  in  4  the ALU operation code.
REQ-013 SHALL have IN_IS_LOAD  in  1  the instruction is a load.
REQ-014 SHALL have FLUSH  in  1  kill the held instruction and the offered instruction.
REQ-015 SHALL have FWD_EX_VALID, FWD_EX_IS_LOAD  in  1 each; FWD_EX_RD  in  5; FWD_EX_DATA  in  WIDTH+1  the ALU-output-stage producer.
REQ-016 SHALL have FWD_WB_VALID  in  1; FWD_WB_RD  in  5; FWD_WB_DATA  in  WIDTH+1  the writeback producer.
REQ-017 SHALL have OUT_READY  in  1  the ALU stage consumes the held instruction.
REQ-018 SHALL have OUT_VALID  out  1  A, B, REG_CONTROL, OUT_RD and OUT_IS_LOAD are valid.
REQ-019 SHALL have A and B  out  WIDTH+1 signed each  the registered ALU operands.
REQ-020 SHALL have REG_CONTROL  out  4  the registered ALU operation.
REQ-021 SHALL have OUT_RD  out  5 and OUT_IS_LOAD  out  1  the registered destination and load flag.

Function
REQ-022 SHALL be a single-entry stage with states EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
REQ-023 SHALL drive IN_READY = (!OUT_VALID || OUT_READY) && !HAZARD && !FLUSH, where IN_READY is combinational.
REQ-024 SHALL capture the instruction on the edge where IN_VALID && IN_READY; OUT_VALID is 1 in the next cycle.
REQ-025 SHALL go to EMPTY on OUT_VALID && OUT_READY with no capture, and update directly from FULL to FULL on simultaneous consume and capture (full throughput, no bubble).
REQ-026 SHALL hold all outputs stable while FULL && !OUT_READY.
REQ-027 SHALL resolve each needed source at capture with priority: index 0 -> 0; FWD_EX match (FWD_EX_VALID, not a load) -> FWD_EX_DATA; FWD_WB match -> FWD_WB_DATA; otherwise the register-file value.
REQ-028 SHALL select A = IN_USE_PC ? IN_PC : forwarded rs1 and B = IN_USE_IMM ? IN_IMM : forwarded rs2.
REQ-029 SHALL raise HAZARD when IN_VALID && FWD_EX_VALID && FWD_EX_IS_LOAD && FWD_EX_RD != 0 and FWD_EX_RD equals a source that is actually used; rs1 is unused when IN_USE_PC and rs2 is unused when IN_USE_IMM.
REQ-030 SHALL let a FULL instruction drain during HAZARD; if it drains, the stage goes EMPTY for that cycle (bubble).
REQ-031 SHALL clear OUT_VALID on the edge after FLUSH and block capture in the FLUSH cycle; FLUSH wins over consume, capture and hazard.
REQ-032 SHALL pass IN_CONTROL through unmodified, with no arithmetic performed in this stage.

Reset
REQ-033 SHALL asynchronously set OUT_VALID=0, A=0, B=0, REG_CONTROL=4'b1111 (NOP, ALU result 0), OUT_RD=0 and OUT_IS_LOAD=0 while reset=1.
REQ-034 SHALL drop an in-flight instruction when reset asserts mid-operation, and SHALL NOT capture on the first edge after release unless IN_VALID && IN_READY.

Structure
REQ-035 SHALL take ALU control encodings from a shared package alu_pkg: AND 0000, OR 0001, ADD 0010, MUL 0011, AUIPC 0100, SUB 0101, BEQ 0110, SLL 0111, SLTI 1000, NOP 1111; alu_pkg also defines REG_IDX_W=5.
REQ-036 SHALL instantiate sub-module operand_forward (combinational priority mux plus load-match flag) twice, once for rs1 and once for rs2.

Verification
REQ-037 SHALL pass the ADD case: IN_RS1_DATA=5, IN_RS2_DATA=7, IN_CONTROL=0010, no forwarding -> next cycle OUT_VALID=1, A=5, B=7, REG_CONTROL=0010.
REQ-038 SHALL pass the forward-priority case: IN_RS1=3, FWD_EX_RD=3 with data 9, FWD_WB_RD=3 with data 4 -> A=9; the same case with FWD_EX_VALID=0 -> A=4; IN_RS1=0 with both producers matching -> A=0.
REQ-039 SHALL pass the load-use case: FWD_EX_IS_LOAD=1, FWD_EX_RD=IN_RS2=6, IN_USE_IMM=0 -> IN_READY=0 and one bubble; the same case with IN_USE_IMM=1 -> no stall.
REQ-040 SHALL pass the backpressure case: OUT_READY=0 for 3 cycles while FULL -> outputs held and IN_READY=0; then OUT_READY=1 with IN_VALID=1 -> back-to-back capture with no bubble.
REQ-041 SHALL pass the flush/reset case: FLUSH together with IN_VALID and OUT_READY -> OUT_VALID=0 next cycle and nothing captured; reset asserted while FULL -> OUT_VALID=0 and REG_CONTROL=1111 immediately.
